// File: rtl/wb_pkg.sv
// wb_pkg: shared Wishbone bus defaults and arbiter state type
package wb_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 32;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: upstream master bundle and downstream port of the Wishbone arbiter
interface wb_arbiter_if import wb_pkg::*; #(
  parameter int Count = 2,
  parameter int DataWidth = DEF_DATA_WIDTH,
  parameter int AddrWidth = DEF_ADDR_WIDTH,
  localparam int SelWidth = DataWidth / 8
);
  logic [Count-1:0][DataWidth-1:0] m_data_m;
  logic [Count-1:0][DataWidth-1:0] m_data_s;
  logic [Count-1:0][AddrWidth-1:0] m_addr;
  logic [Count-1:0][SelWidth-1:0] m_sel;
  logic [Count-1:0] m_cyc;
  logic [Count-1:0] m_stb;
  logic [Count-1:0] m_we;
  logic [Count-1:0] m_ack;
  logic [Count-1:0] m_err;
  logic [Count-1:0] m_stall;
  logic [DataWidth-1:0] s_data_m;
  logic [DataWidth-1:0] s_data_s;
  logic [AddrWidth-1:0] s_addr;
  logic [SelWidth-1:0] s_sel;
  logic s_we;
  logic s_cyc;
  logic s_stb;
  logic s_ack;
  logic s_err;
  logic s_stall;
  modport master (
    output m_data_m, m_addr, m_sel, m_cyc, m_stb, m_we,
    output s_data_s, s_ack, s_err, s_stall,
    input  m_data_s, m_ack, m_err, m_stall,
    input  s_data_m, s_addr, s_sel, s_we, s_cyc, s_stb
  );
  modport slave (
    input  m_data_m, m_addr, m_sel, m_cyc, m_stb, m_we,
    input  s_data_s, s_ack, s_err, s_stall,
    output m_data_s, m_ack, m_err, m_stall,
    output s_data_m, s_addr, s_sel, s_we, s_cyc, s_stb
  );
endinterface

// File: rtl/rr_picker.sv
// rr_picker: rotating-priority search for the first request after last
module rr_picker #(
  parameter int Count = 2,
  localparam int IdxWidth = Count > 1 ? $clog2(Count) : 1
) (
  input  logic [Count-1:0]    req,
  input  logic [IdxWidth-1:0] last,
  output logic                valid,
  output logic [IdxWidth-1:0] idx
);
  logic [Count-1:0] rot;
  // Rotate so bit 0 is last+1, then take the lowest set bit
  always_comb begin
    rot = Count'({req, req} >> (int'(last) + 1));
    valid = |req;
    idx = '0;
    for (int k = Count - 1; k >= 0; k--)
      if (rot[k]) idx = IdxWidth'((int'(last) + 1 + k) % Count);
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin arbiter merging Count Wishbone masters onto one port
module wb_arbiter import wb_pkg::*; #(
  parameter int Count = 2,
  parameter int DataWidth = DEF_DATA_WIDTH,
  parameter int AddrWidth = DEF_ADDR_WIDTH,
  localparam int SelWidth = DataWidth / 8,
  localparam int IdxWidth = Count > 1 ? $clog2(Count) : 1
) (
  input logic         clk,
  input logic         reset_n,
  wb_arbiter_if.slave bus
);
  arb_state_e state;
  logic [IdxWidth-1:0] owner, last, win;
  logic win_valid, busy, own_cyc;
  logic [DataWidth-1:0] own_data;
  logic [AddrWidth-1:0] own_addr;
  logic [SelWidth-1:0] own_sel;

  rr_picker #(.Count(Count)) u_picker (
    .req(bus.m_cyc),
    .last(last),
    .valid(win_valid),
    .idx(win)
  );

  // Grant one edge after a request in IDLE; hold until the owner drops cyc
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= ARB_IDLE;
      owner <= '0;
      last <= IdxWidth'(Count - 1);
    end else if (state == ARB_IDLE) begin
      if (win_valid) begin
        owner <= win;
        state <= ARB_BUSY;
      end
    end else if (!bus.m_cyc[owner]) begin
      last <= owner;
      state <= ARB_IDLE;
    end

  // Forward the owner's request downstream and steer the response back to it
  always_comb begin
    busy = state == ARB_BUSY;
    own_cyc = busy && bus.m_cyc[owner];
    own_data = bus.m_data_m[owner];
    own_addr = bus.m_addr[owner];
    own_sel = bus.m_sel[owner];
    bus.s_cyc = own_cyc;
    bus.s_stb = own_cyc && bus.m_stb[owner];
    bus.s_we = bus.m_we[owner];
    bus.s_data_m = own_data;
    bus.s_addr = own_addr;
    bus.s_sel = own_sel;
    bus.m_ack = busy ? (Count'(bus.s_ack) << owner) : '0;
    bus.m_err = busy ? (Count'(bus.s_err) << owner) : '0;
    bus.m_stall = busy ? ~(Count'(!bus.s_stall) << owner) : '1;
    bus.m_data_s = {Count{bus.s_data_s}};
  end
endmodule
